// File: rtl/pmem_line_responder.sv
// pmem_line_responder
//   Line-granular backing store that answers the cache's pmem handshake.
//   One read or write is accepted from IDLE and completed LATENCY cycles
//   later with a single-cycle o_pmem_resp pulse.
//
// Ports
//   i_clk           clock, all logic on posedge
//   i_rst_n         synchronous active-low reset
//   i_pmem_read     line read request, level, held until resp
//   i_pmem_write    line write request, level, held until resp
//   i_pmem_address  byte address; line index = i_pmem_address[5 +: IDX]
//   i_pmem_wdata    write line
//   o_pmem_rdata    read line, registered, holds until the next read completes
//   o_pmem_resp     completion pulse, one cycle per accepted request
//   o_busy          high while a transaction is in flight (BUSY and RESP)
//   o_proto_err     sticky, set when read and write are both high at accept
//
// state  | meaning
// S_IDLE | waiting for a request; accepts on read or write high
// S_BUSY | latency countdown; aborts if the latched op's request drops
// S_RESP | resp pulse; write commits at the edge leaving this state
module pmem_line_responder #(
    parameter int LINE_BITS = 256,
    parameter int DEPTH     = 64,
    parameter int LATENCY   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_pmem_read,
    input  logic                 i_pmem_write,
    input  logic [31:0]          i_pmem_address,
    input  logic [LINE_BITS-1:0] i_pmem_wdata,
    output logic [LINE_BITS-1:0] o_pmem_rdata,
    output logic                 o_pmem_resp,
    output logic                 o_busy,
    output logic                 o_proto_err
);

    localparam int IDX   = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX-1:0]        r_idx;
    logic                  r_op_wr;
    logic [LINE_BITS-1:0]  r_wdata;
    logic [LINE_BITS-1:0]  r_rdata;
    logic                  r_resp;
    logic                  r_busy;
    logic                  r_proto_err;
    logic [LINE_BITS-1:0]  r_store [DEPTH];

    logic                  w_accept;
    logic                  w_load_rd;
    logic                  w_commit;
    logic                  w_req_held;
    logic [IDX-1:0]        w_idx_in;
    logic [IDX-1:0]        w_rd_idx;
    logic                  w_unused_addr;

    assign w_idx_in      = i_pmem_address[5 +: IDX];
    // Line offset and alias bits above the index carry no information here.
    assign w_unused_addr = ^{i_pmem_address[4:0], i_pmem_address[31:5+IDX]};
    assign w_req_held    = r_op_wr ? i_pmem_write : i_pmem_read;
    // With LATENCY = 1 the read is loaded on the accept edge, before r_idx is valid.
    assign w_rd_idx      = (r_state == S_IDLE) ? w_idx_in : r_idx;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_load_rd   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_pmem_read || i_pmem_write) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nxt = S_RESP;
                        w_load_rd   = ~i_pmem_write;
                    end else begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_BUSY: begin
                if (!w_req_held) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                    w_load_rd   = ~r_op_wr;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_commit    = r_op_wr;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_resp      <= 1'b0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_resp  <= (w_state_nxt == S_RESP);
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_accept && i_pmem_read && i_pmem_write) begin
                r_proto_err <= 1'b1;
            end
            if (w_load_rd) begin
                r_rdata <= r_store[w_rd_idx];
            end
        end
    end

    // Request fields need no reset: they are only consumed after an accept.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_idx   <= w_idx_in;
            r_op_wr <= i_pmem_write;
            r_wdata <= i_pmem_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_commit) begin
            r_store[r_idx] <= r_wdata;
        end
    end

    assign o_pmem_rdata = r_rdata;
    assign o_pmem_resp  = r_resp;
    assign o_busy       = r_busy;
    assign o_proto_err  = r_proto_err;

endmodule
